// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: compacts up to NrCommitPorts retired records per cycle,
// tags each one with a retirement order number, and drains them one per cycle to a trace sink.
module rvfi_trace_buffer #(
  parameter type         rvfi_instr_t  = logic,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 16,
  parameter int unsigned OrderWidth    = 64,
  parameter int unsigned DropCntWidth  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  rvfi_instr_t [NrCommitPorts-1:0] rvfi_instr_i,
  input  logic [NrCommitPorts-1:0]        rvfi_valid_i,
  input  logic                            clear_i,
  output logic                            trace_valid_o,
  input  logic                            trace_ready_i,
  output rvfi_instr_t                     trace_instr_o,
  output logic [OrderWidth-1:0]           trace_order_o,
  output logic [$clog2(Depth+1)-1:0]      level_o,
  output logic                            almost_full_o,
  output logic                            overflow_o,
  output logic [DropCntWidth-1:0]         drop_cnt_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LvlW = $clog2(Depth + 1);
  localparam int unsigned CntW = $clog2(NrCommitPorts + 1);
  localparam int unsigned SumW = ((LvlW > CntW) ? LvlW : CntW) + 1;
  localparam int unsigned DcW  = DropCntWidth + SumW;
  localparam logic [DcW-1:0] DropMax = DcW'({DropCntWidth{1'b1}});

  typedef struct packed {
    rvfi_instr_t           instr;
    logic [OrderWidth-1:0] order;
  } entry_t;

  entry_t                  mem_q [Depth];
  entry_t                  mem_d [Depth];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]         level_q, level_d;
  logic [OrderWidth-1:0]   order_q, order_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    almost_full_q, almost_full_d;

  logic                    pop;
  logic [SumW-1:0]         k, free, stored, dropped;
  logic [PtrW-1:0]         slot;
  logic [DcW-1:0]          drop_sum;

  always_comb begin
    pop    = (level_q != '0) && trace_ready_i;
    // A same-cycle pop frees its slot for this cycle's push.
    free   = SumW'(Depth) - SumW'(level_q) + SumW'(pop);
    mem_d  = mem_q;
    k      = '0;
    stored = '0;
    slot   = '0;
    // k doubles as the rank of each valid lane among the valid lanes below it.
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (rvfi_valid_i[i]) begin
        if (!clear_i && (k < free)) begin
          slot              = wr_ptr_q + PtrW'(k);
          mem_d[slot].instr = rvfi_instr_i[i];
          mem_d[slot].order = order_q + OrderWidth'(k);
          stored            = stored + SumW'(1);
        end
        k = k + SumW'(1);
      end
    end

    dropped  = clear_i ? '0 : (k - stored);
    drop_sum = DcW'(drop_cnt_q) + DcW'(dropped);
    order_d  = order_q + OrderWidth'(k);

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + PtrW'(stored);
      rd_ptr_d   = rd_ptr_q + PtrW'(pop);
      level_d    = level_q + LvlW'(stored) - LvlW'(pop);
      drop_cnt_d = (drop_sum > DropMax) ? {DropCntWidth{1'b1}} : drop_sum[DropCntWidth-1:0];
      overflow_d = overflow_q | (dropped != '0);
    end

    almost_full_d = (SumW'(Depth) - SumW'(level_d)) < SumW'(NrCommitPorts);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      order_q       <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      almost_full_q <= (Depth < NrCommitPorts);
    end else begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      order_q       <= order_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign trace_valid_o = (level_q != '0);
  assign trace_instr_o = mem_q[rd_ptr_q].instr;
  assign trace_order_o = mem_q[rd_ptr_q].order;
  assign level_o       = level_q;
  assign almost_full_o = almost_full_q;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Scoreboard bench for rvfi_trace_buffer: a queue model of the FIFO predicts every drained record
// and the level/overflow/drop statistics.
module tb_rvfi_trace_buffer;

  typedef logic [7:0] instr_t;
  typedef struct packed {
    logic [7:0]  instr;
    logic [63:0] order;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  instr_t [1:0]     rvfi_instr;
  logic [1:0]       rvfi_valid;
  logic             clear;
  logic             trace_valid;
  logic             trace_ready;
  instr_t           trace_instr;
  logic [63:0]      trace_order;
  logic [4:0]       level;
  logic             almost_full;
  logic             overflow;
  logic [15:0]      drop_cnt;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] m_order;
  int          m_drop;
  logic        m_ovf;
  logic [7:0]  data_ctr = 8'h10;

  always #5 clk = ~clk;

  rvfi_trace_buffer #(
    .rvfi_instr_t (instr_t),
    .NrCommitPorts(2),
    .Depth        (16),
    .OrderWidth   (64),
    .DropCntWidth (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rvfi_instr_i (rvfi_instr),
    .rvfi_valid_i (rvfi_valid),
    .clear_i      (clear),
    .trace_valid_o(trace_valid),
    .trace_ready_i(trace_ready),
    .trace_instr_o(trace_instr),
    .trace_order_o(trace_order),
    .level_o      (level),
    .almost_full_o(almost_full),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt)
  );

  // One clock of stimulus; called #1 after a rising edge, returns #1 after the next one.
  task automatic cycle(input logic [1:0] v, input logic rdy, input logic clr);
    exp_t e;
    int   free;
    int   j;
    rvfi_valid    = v;
    rvfi_instr[0] = data_ctr;
    rvfi_instr[1] = data_ctr + 8'd1;
    data_ctr      = data_ctr + 8'd2;
    trace_ready   = rdy;
    clear         = clr;
    if (!clr && rdy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (trace_valid !== 1'b1 || trace_instr !== e.instr || trace_order !== e.order) begin
        tests_failed++;
        $display("FAIL pop: got valid=%0b instr=%h order=%0d, expected valid=1 instr=%h order=%0d",
                 trace_valid, trace_instr, trace_order, e.instr, e.order);
      end else begin
        $display("[TB] pop order=%0d instr=%h", trace_order, trace_instr);
      end
    end
    j = 0;
    if (clr) begin
      exp_q.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
      for (int i = 0; i < 2; i++) if (v[i]) j++;
    end else begin
      free = 16 - exp_q.size();
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if (free > 0) begin
            exp_q.push_back('{instr: rvfi_instr[i], order: m_order + 64'(j)});
            free--;
          end else begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
          end
          j++;
        end
      end
    end
    m_order = m_order + 64'(j);
    @(posedge clk);
    #1;
    rvfi_valid  = 2'b00;
    trace_ready = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic do_reset();
    rvfi_valid  = 2'b00;
    rvfi_instr  = '0;
    trace_ready = 1'b0;
    clear       = 1'b0;
    rst_n       = 1'b0;
    #3;
    exp_q.delete();
    m_order = '0;
    m_drop  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) cycle(2'b00, 1'b1, 1'b0);
    tests_run++;
    if (trace_valid !== 1'b0 || level !== 5'd0) begin
      tests_failed++;
      $display("FAIL drain_empty: got valid=%0b level=%0d, expected valid=0 level=0", trace_valid, level);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset();
    tests_run++;
    if (trace_valid !== 1'b0 || trace_instr !== 8'h00 || trace_order !== 64'd0 || level !== 5'd0 ||
        almost_full !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%0b instr=%h order=%0d level=%0d af=%0b ovf=%0b drop=%0d, expected all 0",
               trace_valid, trace_instr, trace_order, level, almost_full, overflow, drop_cnt);
    end
    release_reset();
  endtask

  task automatic test_single_lane();
    do_reset();
    release_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(2'b01, 1'b1, 1'b0);
      tests_run++;
      if (trace_valid !== 1'b1 || trace_order !== 64'(i) || level > 5'd1) begin
        tests_failed++;
        $display("FAIL single_lane[%0d]: got valid=%0b order=%0d level=%0d, expected valid=1 order=%0d level<=1",
                 i, trace_valid, trace_order, level, i);
      end
    end
    drain();
  endtask

  task automatic test_compaction();
    logic [7:0] first_lane1;
    do_reset();
    release_reset();
    first_lane1 = data_ctr + 8'd1;
    cycle(2'b10, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);
    tests_run++;
    if (level !== 5'd3 || trace_order !== 64'd0 || trace_instr !== first_lane1) begin
      tests_failed++;
      $display("FAIL compaction: got level=%0d order=%0d instr=%h, expected level=3 order=0 instr=%h",
               level, trace_order, trace_instr, first_lane1);
    end
    drain();
  endtask

  task automatic test_overflow_and_almost_full();
    do_reset();
    release_reset();
    for (int i = 0; i < 16; i++) cycle(2'b01, 1'b0, 1'b0);
    tests_run++;
    if (level !== 5'd16 || almost_full !== 1'b1 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill16: got level=%0d af=%0b ovf=%0b, expected level=16 af=1 ovf=0", level, almost_full, overflow);
    end
    cycle(2'b11, 1'b0, 1'b0);
    tests_run++;
    if (drop_cnt !== 16'd2 || overflow !== 1'b1 || level !== 5'd16) begin
      tests_failed++;
      $display("FAIL overflow: got drop=%0d ovf=%0b level=%0d, expected drop=2 ovf=1 level=16", drop_cnt, overflow, level);
    end
    cycle(2'b01, 1'b1, 1'b0);
    tests_run++;
    if (drop_cnt !== 16'd2 || level !== 5'd16) begin
      tests_failed++;
      $display("FAIL full_pop_push: got drop=%0d level=%0d, expected drop=2 level=16", drop_cnt, level);
    end
    cycle(2'b00, 1'b1, 1'b0);
    tests_run++;
    if (level !== 5'd15 || almost_full !== 1'b1) begin
      tests_failed++;
      $display("FAIL af_level15: got level=%0d af=%0b, expected level=15 af=1", level, almost_full);
    end
    cycle(2'b00, 1'b1, 1'b0);
    tests_run++;
    if (level !== 5'd14 || almost_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL af_level14: got level=%0d af=%0b, expected level=14 af=0", level, almost_full);
    end
    drain();
  endtask

  task automatic test_clear();
    logic [63:0] old_order;
    do_reset();
    release_reset();
    for (int i = 0; i < 16; i++) cycle(2'b01, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) cycle(2'b00, 1'b1, 1'b0);
    tests_run++;
    if (level !== 5'd5 || drop_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL pre_clear: got level=%0d drop=%0d, expected level=5 drop=3", level, drop_cnt);
    end
    old_order = m_order;
    cycle(2'b11, 1'b0, 1'b1);
    tests_run++;
    if (level !== 5'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || trace_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear: got level=%0d drop=%0d ovf=%0b valid=%0b, expected all 0", level, drop_cnt, overflow, trace_valid);
    end
    cycle(2'b01, 1'b0, 1'b0);
    tests_run++;
    if (trace_valid !== 1'b1 || trace_order !== old_order + 64'd2) begin
      tests_failed++;
      $display("FAIL post_clear_order: got valid=%0b order=%0d, expected valid=1 order=%0d",
               trace_valid, trace_order, old_order + 64'd2);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] v;
    logic       rdy;
    logic       clr;
    int         sz;
    do_reset();
    release_reset();
    for (int n = 0; n < 300; n++) begin
      v   = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 60) == 0);
      cycle(v, rdy, clr);
      sz = exp_q.size();
      tests_run++;
      if (level !== 5'(sz) || drop_cnt !== 16'(m_drop) || overflow !== m_ovf ||
          almost_full !== ((16 - sz) < 2) || trace_valid !== (sz != 0)) begin
        tests_failed++;
        $display("FAIL b2b_stats[%0d]: got level=%0d drop=%0d ovf=%0b af=%0b valid=%0b, expected level=%0d drop=%0d ovf=%0b af=%0b valid=%0b",
                 n, level, drop_cnt, overflow, almost_full, trace_valid,
                 sz, m_drop, m_ovf, ((16 - sz) < 2), (sz != 0));
      end
    end
    drain();
  endtask

  initial begin
    rst_n       = 1'b1;
    rvfi_valid  = 2'b00;
    rvfi_instr  = '0;
    trace_ready = 1'b0;
    clear       = 1'b0;
    m_order     = '0;
    m_drop      = 0;
    m_ovf       = 1'b0;
    test_reset();
    test_single_lane();
    test_compaction();
    test_overflow_and_almost_full();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
